// File: rtl/bram_dump_sequencer.sv
// Sweeps START_ADDR..END_ADDR, reads each byte from a fixed-latency BRAM and
// hands every {addr, data} record to the UART record sender, one at a time.
module bram_dump_sequencer #(
    parameter int          ADDR_W      = 12,
    parameter int          DATA_W      = 8,
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned END_ADDR    = 4095,
    parameter int          RD_LATENCY  = 2,
    parameter int          ACK_TIMEOUT = 1023
) (
    input  logic              CLK_50M,
    input  logic              rst,
    input  logic              start,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              send_enable,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              send_busy,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int                TO_W     = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(END_ADDR);
    localparam logic [1:0]        LAT_LAST = 2'(RD_LATENCY - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_LAT       = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_NEXT      = 3'd6
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [ADDR_W-1:0]   cnt_r, cnt_nxt_s;
    logic [1:0]          lat_cnt_r, lat_cnt_nxt_s;
    logic [TO_W-1:0]     to_cnt_r, to_cnt_nxt_s;
    logic                error_r, error_nxt_s;
    logic                capture_s;
    logic                bram_en_r, send_enable_r, busy_r, done_r;
    logic [ADDR_W-1:0]   bram_addr_r, addr_r;
    logic [DATA_W-1:0]   data_r;

    // Next-state, counter and capture decode for the sweep FSM.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        lat_cnt_nxt_s = lat_cnt_r;
        to_cnt_nxt_s  = to_cnt_r;
        error_nxt_s   = error_r;
        capture_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    error_nxt_s = 1'b0;
                    cnt_nxt_s   = START_A;
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                lat_cnt_nxt_s = 2'd0;
                state_nxt_s   = ST_LAT;
            end
            ST_LAT: begin
                // dout is valid in the last LAT cycle, RD_LATENCY clocks after READ
                if (lat_cnt_r == LAT_LAST) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_SEND;
                end else begin
                    lat_cnt_nxt_s = lat_cnt_r + 2'd1;
                end
            end
            ST_SEND: begin
                to_cnt_nxt_s = {TO_W{1'b0}};
                state_nxt_s  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (send_busy) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else if (to_cnt_r == TO_LAST) begin
                    error_nxt_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    to_cnt_nxt_s = to_cnt_r + TO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (send_busy) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // compare before increment so a sweep ending at the top address never wraps
                if (cnt_r == END_A) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r + ADDR_W'(1);
                    state_nxt_s = ST_READ;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge CLK_50M or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= START_A;
            lat_cnt_r     <= 2'd0;
            to_cnt_r      <= {TO_W{1'b0}};
            error_r       <= 1'b0;
            bram_en_r     <= 1'b0;
            bram_addr_r   <= {ADDR_W{1'b0}};
            send_enable_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            addr_r        <= {ADDR_W{1'b0}};
            data_r        <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            cnt_r         <= cnt_nxt_s;
            lat_cnt_r     <= lat_cnt_nxt_s;
            to_cnt_r      <= to_cnt_nxt_s;
            error_r       <= error_nxt_s;
            bram_en_r     <= (state_nxt_s == ST_READ);
            send_enable_r <= (state_nxt_s == ST_SEND);
            busy_r        <= (state_nxt_s != ST_IDLE);
            done_r        <= (state_nxt_s == ST_NEXT) && (cnt_nxt_s == END_A);
            if (state_nxt_s == ST_READ) begin
                bram_addr_r <= cnt_nxt_s;
            end
            if (capture_s) begin
                addr_r <= cnt_r;
                data_r <= bram_dout;
            end
        end
    end

    assign bram_en     = bram_en_r;
    assign bram_addr   = bram_addr_r;
    assign send_enable = send_enable_r;
    assign addr        = addr_r;
    assign data        = data_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;

endmodule

// File: tb/tb_bram_dump_sequencer.sv
// Bench for bram_dump_sequencer: four differently parameterised instances, a BRAM
// and sender model each, and a scoreboard of expected records checked on send_enable.
`timescale 1ns/1ps
module tb_bram_dump_sequencer;

    localparam int N_DUT  = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    function automatic int cfg_start(input int i);
        case (i)
            0:       return 0;
            1:       return 5;
            2:       return 32'hFFE;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_end(input int i);
        case (i)
            0:       return 15;
            1:       return 5;
            2:       return 32'hFFF;
            default: return 7;
        endcase
    endfunction

    function automatic int cfg_lat(input int i);
        case (i)
            0:       return 2;
            1:       return 2;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_to(input int i);
        case (i)
            0:       return 15;
            default: return 1023;
        endcase
    endfunction

    function automatic logic [7:0] bram_val(input logic [11:0] a);
        if (a == 12'h005) return 8'hA7;
        return a[7:0] ^ 8'h5A;
    endfunction

    typedef struct {
        int          inst;
        logic [11:0] addr;
        logic [7:0]  data;
    } rec_t;

    typedef struct {
        int   inst;
        int   dly;
        int   len;
        int   n_rec;
        int   exp_done;
        logic exp_err;
    } vec_t;

    logic CLK_50M = 1'b0;
    logic rst     = 1'b1;

    logic              start_s       [N_DUT];
    logic              bram_en_s     [N_DUT];
    logic [ADDR_W-1:0] bram_addr_s   [N_DUT];
    logic              send_enable_s [N_DUT];
    logic [ADDR_W-1:0] addr_s        [N_DUT];
    logic [DATA_W-1:0] data_s        [N_DUT];
    logic              busy_s        [N_DUT];
    logic              done_s        [N_DUT];
    logic              error_s       [N_DUT];

    int   busy_dly    = 1;
    int   busy_len    = 1;
    bit   sender_mute = 1'b0;

    rec_t        exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          en_cyc   [N_DUT];
    int          rec_cnt  [N_DUT];
    int          done_cnt [N_DUT];
    bit          hold_v   [N_DUT];
    logic [11:0] hold_a   [N_DUT];
    logic [7:0]  hold_d   [N_DUT];

    always #10 CLK_50M = ~CLK_50M;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        logic [7:0] p1, p2, p3, dout_g;
        logic       busy_m, pend;
        int         dly_cnt, len_cnt;

        bram_dump_sequencer #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W),
            .START_ADDR(cfg_start(g)), .END_ADDR(cfg_end(g)),
            .RD_LATENCY(cfg_lat(g)), .ACK_TIMEOUT(cfg_to(g))
        ) u_dut (
            .CLK_50M(CLK_50M), .rst(rst), .start(start_s[g]),
            .bram_en(bram_en_s[g]), .bram_addr(bram_addr_s[g]), .bram_dout(dout_g),
            .send_enable(send_enable_s[g]), .addr(addr_s[g]), .data(data_s[g]),
            .send_busy(busy_m), .busy(busy_s[g]), .done(done_s[g]), .error(error_s[g])
        );

        // BRAM model: read pipeline, dout taken RD_LATENCY stages after en/addr.
        always @(posedge CLK_50M) begin
            if (bram_en_s[g]) p1 <= bram_val(bram_addr_s[g]);
            p2 <= p1;
            p3 <= p2;
        end
        assign dout_g = (cfg_lat(g) == 1) ? p1 : (cfg_lat(g) == 2) ? p2 : p3;

        // Sender model: busy rises busy_dly clocks after send_enable, lasts busy_len.
        always @(posedge CLK_50M or posedge rst) begin
            if (rst) begin
                pend <= 1'b0; busy_m <= 1'b0; dly_cnt <= 0; len_cnt <= 0;
            end else if (send_enable_s[g] && !sender_mute) begin
                pend <= 1'b1; dly_cnt <= busy_dly; len_cnt <= busy_len;
            end else if (pend) begin
                if (dly_cnt <= 1) begin pend <= 1'b0; busy_m <= 1'b1; end
                else dly_cnt <= dly_cnt - 1;
            end else if (busy_m) begin
                if (len_cnt <= 1) busy_m <= 1'b0;
                else len_cnt <= len_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_sweep(input int inst, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            logic [11:0] a;
            a = 12'(first + k);
            exp_q.push_back('{inst: inst, addr: a, data: bram_val(a)});
        end
    endtask

    task automatic monitor();
        int   cyc;
        rec_t e;
        cyc = 0;
        forever begin
            @(negedge CLK_50M);
            cyc++;
            for (int i = 0; i < N_DUT; i++) begin
                if (rst) begin
                    hold_v[i] = 1'b0;
                end else begin
                    if (hold_v[i])
                        chk($sformatf("hold%0d", i), 32'({addr_s[i], data_s[i]}),
                            32'({hold_a[i], hold_d[i]}));
                    if (bram_en_s[i]) begin
                        en_cyc[i] = cyc;
                        hold_v[i] = 1'b0;
                        chk($sformatf("read_addr%0d", i), 32'(bram_addr_s[i]),
                            (exp_q.size() > 0) ? 32'(exp_q[0].addr) : 32'hFFFF_FFFF);
                    end
                    if (send_enable_s[i]) begin
                        if (exp_q.size() > 0) e = exp_q.pop_front();
                        else e = '{inst: -1, addr: 12'hFFF, data: 8'hFF};
                        chk($sformatf("rec_inst%0d", i), 32'(i), 32'(e.inst));
                        chk($sformatf("rec_addr%0d", i), 32'(addr_s[i]), 32'(e.addr));
                        chk($sformatf("rec_data%0d", i), 32'(data_s[i]), 32'(e.data));
                        chk($sformatf("send_lat%0d", i), 32'(cyc - en_cyc[i]), 32'(cfg_lat(i) + 1));
                        hold_v[i] = 1'b1;
                        hold_a[i] = addr_s[i];
                        hold_d[i] = data_s[i];
                        rec_cnt[i]++;
                    end
                    if (done_s[i]) done_cnt[i]++;
                end
            end
        end
    endtask

    task automatic pulse_start(input int i);
        @(negedge CLK_50M);
        start_s[i] = 1'b1;
        @(negedge CLK_50M);
        start_s[i] = 1'b0;
        chk($sformatf("start_busy%0d", i), 32'(busy_s[i]), 32'd1);
        chk($sformatf("start_clr_err%0d", i), 32'(error_s[i]), 32'd0);
    endtask

    task automatic wait_idle(input int i, input int max_cyc);
        int n;
        n = 0;
        while (busy_s[i] && n < max_cyc) begin
            @(negedge CLK_50M);
            n++;
        end
        chk($sformatf("idle_wait%0d", i), 32'(busy_s[i]), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{inst: 1, dly: 3, len: 100, n_rec: 1,  exp_done: 1, exp_err: 1'b0};
        vecs[1] = '{inst: 0, dly: 1, len: 2,   n_rec: 16, exp_done: 1, exp_err: 1'b0};
        vecs[2] = '{inst: 2, dly: 2, len: 5,   n_rec: 2,  exp_done: 1, exp_err: 1'b0};
        vecs[3] = '{inst: 3, dly: 1, len: 1,   n_rec: 8,  exp_done: 1, exp_err: 1'b0};
        vecs[4] = '{inst: 0, dly: 3, len: 7,   n_rec: 16, exp_done: 1, exp_err: 1'b0};
        for (int i = 0; i < N_DUT; i++) begin
            start_s[i] = 1'b0; en_cyc[i] = 0; rec_cnt[i] = 0; done_cnt[i] = 0; hold_v[i] = 1'b0;
        end
        fork
            monitor();
        join_none

        @(negedge CLK_50M);
        for (int i = 0; i < N_DUT; i++) begin
            chk($sformatf("rst_ctl%0d", i),
                32'({busy_s[i], bram_en_s[i], send_enable_s[i], done_s[i], error_s[i]}), 32'd0);
            chk($sformatf("rst_bus%0d", i), {bram_addr_s[i], addr_s[i], data_s[i]}, 32'd0);
        end
        rst = 1'b0;

        // Ack timeout: sender never answers; error after the SEND cycle plus 16 WAIT_ACK cycles.
        sender_mute = 1'b1;
        done_cnt[0] = 0;
        push_sweep(0, 0, 1);
        pulse_start(0);
        n = 0;
        while (!send_enable_s[0] && n < 50) begin @(negedge CLK_50M); n++; end
        chk("to_send_enable", 32'(send_enable_s[0]), 32'd1);
        n = 0;
        while (!error_s[0] && n < 100) begin @(negedge CLK_50M); n++; end
        chk("to_error_delay", 32'(n), 32'd17);
        chk("to_busy", 32'(busy_s[0]), 32'd0);
        repeat (5) @(negedge CLK_50M);
        chk("to_error_sticky", 32'(error_s[0]), 32'd1);
        chk("to_no_done", 32'(done_cnt[0]), 32'd0);
        sender_mute = 1'b0;

        // Extra starts mid-sweep are ignored; rst at the 3rd record aborts the sweep.
        busy_dly = 1; busy_len = 4; done_cnt[3] = 0; rec_cnt[3] = 0;
        push_sweep(3, 0, 3);
        pulse_start(3);
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(negedge CLK_50M);
            start_s[3] = 1'b1;
            @(negedge CLK_50M);
            start_s[3] = 1'b0;
        end
        n = 0;
        while (rec_cnt[3] < 3 && n < 200) begin @(negedge CLK_50M); n++; end
        chk("rst_rec_cnt", 32'(rec_cnt[3]), 32'd3);
        @(negedge CLK_50M);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ctl", 32'({busy_s[3], bram_en_s[3], send_enable_s[3], error_s[3]}), 32'd0);
        @(negedge CLK_50M);
        @(negedge CLK_50M);
        rst = 1'b0;
        repeat (4) @(negedge CLK_50M);
        chk("rst_no_done", 32'(done_cnt[3]), 32'd0);
        chk("rst_busy", 32'(busy_s[3]), 32'd0);
        chk("rst_pending", 32'(exp_q.size()), 32'd0);

        // Table-driven sweeps; vector 3 restarts inst 3 at address 0 after the rst.
        for (int v = 0; v < 5; v++) begin
            busy_dly = vecs[v].dly;
            busy_len = vecs[v].len;
            done_cnt[vecs[v].inst] = 0;
            push_sweep(vecs[v].inst, cfg_start(vecs[v].inst), vecs[v].n_rec);
            pulse_start(vecs[v].inst);
            wait_idle(vecs[v].inst, 5000);
            repeat (2) @(negedge CLK_50M);
            chk($sformatf("v%0d_done", v), 32'(done_cnt[vecs[v].inst]), 32'(vecs[v].exp_done));
            chk($sformatf("v%0d_error", v), 32'(error_s[vecs[v].inst]), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_pending", v), 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
